// File: rtl/memory_arbiter.sv
// Arbitrates CPUS instruction/data cache pairs onto one single-ported RAM; data beats instruction, round-robin within each class.
// A request seen in IDLE drives the RAM the next cycle; requesters are held off by iwait/dwait until ramstate==ACCESS.
module memory_arbiter #(
   parameter int CPUS   = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                           CLK,
   input  logic                           nRST,
   input  logic [CPUS-1:0]                iREN,
   input  logic [CPUS-1:0]                dREN,
   input  logic [CPUS-1:0]                dWEN,
   input  logic [CPUS-1:0][ADDR_W-1:0]    iaddr,
   input  logic [CPUS-1:0][ADDR_W-1:0]    daddr,
   input  logic [CPUS-1:0][DATA_W-1:0]    dstore,
   output logic [CPUS-1:0]                iwait,
   output logic [CPUS-1:0]                dwait,
   output logic [CPUS-1:0][DATA_W-1:0]    iload,
   output logic [CPUS-1:0][DATA_W-1:0]    dload,
   output logic                           ramREN,
   output logic                           ramWEN,
   output logic [ADDR_W-1:0]              ramaddr,
   output logic [DATA_W-1:0]              ramstore,
   input  logic [DATA_W-1:0]              ramload,
   input  logic [1:0]                     ramstate
);

   localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   gnt_cpu, gnt_cpu_nxt;
   logic            gnt_d, gnt_d_nxt;
   logic [CW-1:0]   d_ptr, d_ptr_nxt;
   logic [CW-1:0]   i_ptr, i_ptr_nxt;

   logic [CPUS-1:0] dreq;
   logic [CPUS-1:0] ireq;
   logic            gnt_req;
   logic            active;
   logic            ram_access;
   logic [CW-1:0]   ptr_inc;

   // First set bit of req at or after ptr, wrapping modulo CPUS.
   function automatic logic [CW-1:0] pick(input logic [CPUS-1:0] req, input logic [CW-1:0] ptr);
      logic [2*CPUS-1:0] rot;
      logic [CW-1:0]     sel;
      logic              found;
      int                idx;
      rot   = {req, req} >> ptr;
      sel   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < CPUS; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            idx   = int'(ptr) + k;
            if (idx >= CPUS) idx = idx - CPUS;
            sel   = CW'(idx);
         end
      end
      return sel;
   endfunction

   assign dreq       = dREN | dWEN;
   assign ireq       = iREN;
   assign ram_access = (ramstate == RAM_ACCESS);
   assign gnt_req    = gnt_d ? dreq[gnt_cpu] : ireq[gnt_cpu];
   assign active     = (state == GRANT) && gnt_req;
   assign ptr_inc    = (gnt_cpu == CW'(CPUS - 1)) ? '0 : gnt_cpu + 1'b1;

   assign iload = {CPUS{ramload}};
   assign dload = {CPUS{ramload}};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         gnt_cpu <= '0;
         gnt_d   <= 1'b0;
         d_ptr   <= '0;
         i_ptr   <= '0;
      end else begin
         state   <= state_nxt;
         gnt_cpu <= gnt_cpu_nxt;
         gnt_d   <= gnt_d_nxt;
         d_ptr   <= d_ptr_nxt;
         i_ptr   <= i_ptr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      gnt_cpu_nxt = gnt_cpu;
      gnt_d_nxt   = gnt_d;
      d_ptr_nxt   = d_ptr;
      i_ptr_nxt   = i_ptr;
      iwait       = ireq;
      dwait       = dreq;
      ramREN      = 1'b0;
      ramWEN      = 1'b0;
      ramaddr     = '0;
      ramstore    = '0;

      case (state)
         IDLE: begin
            if (|dreq) begin
               state_nxt   = GRANT;
               gnt_d_nxt   = 1'b1;
               gnt_cpu_nxt = pick(dreq, d_ptr);
            end else if (|ireq) begin
               state_nxt   = GRANT;
               gnt_d_nxt   = 1'b0;
               gnt_cpu_nxt = pick(ireq, i_ptr);
            end
         end
         GRANT: begin
            // A dropped request cancels without advancing the pointer; ERROR just keeps waiting.
            if (!gnt_req) begin
               state_nxt = IDLE;
            end else if (ram_access) begin
               state_nxt = IDLE;
               if (gnt_d) d_ptr_nxt = ptr_inc;
               else       i_ptr_nxt = ptr_inc;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (active) begin
         ramaddr  = gnt_d ? daddr[gnt_cpu] : iaddr[gnt_cpu];
         ramstore = dstore[gnt_cpu];
         ramREN   = !gnt_d || dREN[gnt_cpu];
         ramWEN   = gnt_d && !dREN[gnt_cpu] && dWEN[gnt_cpu];
         if (ram_access) begin
            if (gnt_d) dwait[gnt_cpu] = 1'b0;
            else       iwait[gnt_cpu] = 1'b0;
         end
      end
   end

endmodule
